cp0_regfile_p: RTL and testbench
================================

// Module: cp0_regfile_p
// PURPOSE
//  Parametrised MIPS CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
//  Sits beside WB stage; WB drives exception/ERET/MTC0 writes, MFC0 reads via separate
//  read port. Adds programmable Count prescaler, variable external-interrupt width,
//  independent read address, and optional interrupt-input synchronisation.
// PARAMETERS
//  EXT_INT_W  6  number of external interrupt lines (1..6), mapped to Cause.IP[2+:EXT_INT_W]
//  COUNT_DIV  2  clk cycles per Count increment (1..16)
//  RESET_BEV  1  constant value of Status.BEV
// PORTS
//  clk          in   1          clock
//  reset        in   1          synchronous, active-high reset
//  ext_int_in   in   EXT_INT_W  level-sensitive hardware interrupts
//  wb_ex        in   1          exception committed in WB this cycle
//  wb_excode    in   5          ExcCode of that exception
//  wb_badvaddr  in   32         faulting virtual address
//  wb_bd        in   1          faulting instruction is in a delay slot
//  wb_pc        in   32         PC of faulting instruction
//  eret_flush   in   1          ERET committed in WB
//  mtc0_we      in   1          MTC0 write enable
//  c0_waddr     in   5          MTC0 register number (rd; sel=0 only)
//  c0_wdata     in   32         MTC0 data
//  c0_raddr     in   5          MFC0 register number
//  rdata        out  32         MFC0 data (combinational on c0_raddr)
//  epc          out  32         current EPC
//  has_int      out  1          interrupt pending and enabled
// BEHAVIOUR
//  - Reg numbers: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14; others read 0.
//  - Status read: {9'b0,BEV,6'b0,IM[7:0],6'b0,EXL,IE}; Cause read: {BD,TI,14'b0,IP[7:0],1'b0,ExcCode,2'b0}.
//  - Reset: Count, Compare, BadVAddr, EPC=0; IM=0, EXL=0, IE=0; BD, TI, IP, ExcCode=0;
//    prescaler=0. Hence rdata(Status)=RESET_BEV<<22, has_int=0 after reset.
//  - Write priority per cycle: wb_ex > eret_flush > mtc0_we. Any MTC0 in a cycle with
//    wb_ex or eret_flush is dropped.
//  - wb_ex: EXL<=1; ExcCode<=wb_excode; if EXL was 0: BD<=wb_bd, EPC<=wb_bd?wb_pc-4:wb_pc;
//    BadVAddr<=wb_badvaddr only when excode is AdEL(4) or AdES(5).
//  - eret_flush (no wb_ex): EXL<=0. All other fields unchanged.
//  - MTC0 writable fields: Count, Compare, EPC (full); Status IM[15:8], EXL[1], IE[0];
//    Cause IP[1:0] from wdata[9:8]. BadVAddr, BEV, IP[7:2], TI, BD, ExcCode read-only.
//  - Prescaler: counts 0..COUNT_DIV-1; Count+=1 (mod 2^32, wraps FFFF_FFFF->0) in cycles
//    where prescaler==COUNT_DIV-1. MTC0 to Count loads value and resets prescaler to 0
//    that cycle (no increment). COUNT_DIV=1: increments every cycle.
//  - TI: set in the cycle after Count==Compare (level compare, registered); MTC0 to
//    Compare clears TI and takes priority over a set in the same cycle. TI stays set
//    until Compare written; reset does not require Count!=Compare (0==0 after reset sets TI).
//  - IP[7] <= ext_int[5] | TI (if EXT_INT_W==6 else TI); IP[6:2] <= ext_int bits present,
//    absent bits 0. Latency ext_int_in -> IP: 1 cycle (see CONFIGURATION).
//  - has_int = |(IP & IM) & IE & ~EXL, combinational from registers.
//  - rdata reflects register state before the current-cycle write (no write bypass).
//  - Reset asserted mid-exception: reset wins over all inputs that cycle.
// CONFIGURATION
//  CP0_INT_SYNC_EN defined: ext_int_in passes a 2-flop synchroniser (reset 0) before IP
//    capture; ext_int_in -> IP latency 3 cycles, has_int 3 cycles after edge.
//  Not defined: ext_int_in sampled directly; latency 1 cycle. TI path unaffected.
// TESTING
//  1 Reset -> rdata for raddr 12 = 0040_0000, raddr 13 = 0, has_int=0; TI=1 one cycle later.
//  2 COUNT_DIV=2, MTC0 Count=FFFF_FFFE -> Count reads FFFF_FFFF after 2 clk, 0000_0000 after 4.
//  3 MTC0 Compare=10, Count=5 -> TI set 1 cycle after Count==10; MTC0 Compare=20 clears TI.
//  4 Status=0000_0401 (IM[2],IE), ext_int_in[0]=1 -> has_int=1 after 1 cycle
//    (3 with CP0_INT_SYNC_EN); wb_ex excode=0 -> EXL=1, has_int=0; eret_flush -> has_int=1.
//  5 wb_ex excode=4, bd=1, pc=BFC0_0104, badvaddr=1234_5671 -> EPC=BFC0_0100, BD=1,
//    BadVAddr=1234_5671; second wb_ex with EXL=1 leaves EPC/BD unchanged, ExcCode updated.
//  6 wb_ex, eret_flush and MTC0 Status=0 same cycle -> EXL=1, IE/IM unchanged.

Source files
------------

// File: rtl/cp0_regfile_p_if.sv
// WB-stage <-> CP0 bundle: exception/ERET/MTC0 write side plus MFC0 read port.
// Latency: none of its own; pure wiring between WB and the register file.
// Backpressure: none; CP0 accepts every WB request in the cycle it is presented.
interface cp0_regfile_p_if;
  logic        wb_ex;
  logic [4:0]  wb_excode;
  logic [31:0] wb_badvaddr;
  logic        wb_bd;
  logic [31:0] wb_pc;
  logic        eret_flush;
  logic        mtc0_we;
  logic [4:0]  c0_waddr;
  logic [31:0] c0_wdata;
  logic [4:0]  c0_raddr;
  logic [31:0] rdata;
  logic [31:0] epc;
  logic        has_int;

  modport master (
    output wb_ex, wb_excode, wb_badvaddr, wb_bd, wb_pc, eret_flush,
           mtc0_we, c0_waddr, c0_wdata, c0_raddr,
    input  rdata, epc, has_int
  );

  modport slave (
    input  wb_ex, wb_excode, wb_badvaddr, wb_bd, wb_pc, eret_flush,
           mtc0_we, c0_waddr, c0_wdata, c0_raddr,
    output rdata, epc, has_int
  );
endinterface

// File: rtl/cp0_regfile_p.sv
// MIPS CP0 register file (BadVAddr, Count, Compare, Status, Cause, EPC) beside WB.
// Latency: writes land next edge; rdata/epc/has_int are combinational from registers.
// Backpressure: none; every WB request is accepted. Optional CP0_INT_SYNC_EN adds a 2-flop interrupt synchroniser.
module cp0_regfile_p #(
  parameter int EXT_INT_W = 6,
  parameter int COUNT_DIV = 2,
  parameter bit RESET_BEV = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [EXT_INT_W-1:0] ext_int_in,
  cp0_regfile_p_if.slave       bus
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam int            PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [31:0]   badvaddr, count, compare, epc_q;
  logic [7:0]    im;
  logic          exl, ie, bd, ti;
  logic [5:0]    ip_hw;      // IP[7:2]
  logic [1:0]    ip_sw;      // IP[1:0], software interrupts
  logic [4:0]    excode;
  logic [PW-1:0] presc;
  logic [7:0]    ip;

  logic [EXT_INT_W-1:0] ext_s;
  logic [5:0]           ext6;

  // MTC0 only takes effect when no exception or ERET commits in the same cycle.
  logic mtc0_ok, wr_count, wr_compare, wr_status, wr_cause, wr_epc, presc_tick;

  assign mtc0_ok    = bus.mtc0_we & ~bus.wb_ex & ~bus.eret_flush;
  assign wr_count   = mtc0_ok & (bus.c0_waddr == REG_COUNT);
  assign wr_compare = mtc0_ok & (bus.c0_waddr == REG_COMPARE);
  assign wr_status  = mtc0_ok & (bus.c0_waddr == REG_STATUS);
  assign wr_cause   = mtc0_ok & (bus.c0_waddr == REG_CAUSE);
  assign wr_epc     = mtc0_ok & (bus.c0_waddr == REG_EPC);
  assign presc_tick = (presc == PRESC_MAX);
  assign ip         = {ip_hw, ip_sw};

`ifdef CP0_INT_SYNC_EN
  logic [EXT_INT_W-1:0] sync1, sync2;

  // Two-flop synchroniser for asynchronous interrupt lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ext_int_in;
      sync2 <= sync1;
    end
  end

  assign ext_s = sync2;
`else
  assign ext_s = ext_int_in;
`endif

  // Unused interrupt lines read as zero in IP.
  assign ext6 = 6'(ext_s);

  // Count prescaler and Count; an MTC0 to Count restarts the prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      count <= '0;
    end else if (wr_count) begin
      presc <= '0;
      count <= bus.c0_wdata;
    end else if (presc_tick) begin
      presc <= '0;
      count <= count + 32'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Compare and timer interrupt; writing Compare acknowledges the timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      compare <= '0;
      ti      <= 1'b0;
    end else if (wr_compare) begin
      compare <= bus.c0_wdata;
      ti      <= 1'b0;
    end else if (count == compare) begin
      ti      <= 1'b1;
    end
  end

  // Hardware IP bits track interrupt lines with one register stage; TI folds into IP[7].
  always_ff @(posedge clk) begin
    if (reset) begin
      ip_hw <= '0;
      ip_sw <= '0;
    end else begin
      ip_hw <= {ext6[5] | ti, ext6[4:0]};
      if (wr_cause) ip_sw <= bus.c0_wdata[9:8];
    end
  end

  // Status fields: exception sets EXL, ERET clears it, MTC0 writes IM/EXL/IE.
  always_ff @(posedge clk) begin
    if (reset) begin
      im  <= '0;
      exl <= 1'b0;
      ie  <= 1'b0;
    end else if (bus.wb_ex) begin
      exl <= 1'b1;
    end else if (bus.eret_flush) begin
      exl <= 1'b0;
    end else if (wr_status) begin
      im  <= bus.c0_wdata[15:8];
      exl <= bus.c0_wdata[1];
      ie  <= bus.c0_wdata[0];
    end
  end

  // Exception capture; nested exceptions (EXL already set) keep the original EPC/BD.
  always_ff @(posedge clk) begin
    if (reset) begin
      excode   <= '0;
      bd       <= 1'b0;
      epc_q    <= '0;
      badvaddr <= '0;
    end else if (bus.wb_ex) begin
      excode <= bus.wb_excode;
      if (!exl) begin
        bd    <= bus.wb_bd;
        epc_q <= bus.wb_bd ? (bus.wb_pc - 32'd4) : bus.wb_pc;
      end
      if (bus.wb_excode == 5'd4 || bus.wb_excode == 5'd5)
        badvaddr <= bus.wb_badvaddr;
    end else if (wr_epc) begin
      epc_q <= bus.c0_wdata;
    end
  end

  // MFC0 read mux; shows pre-write state, unmapped registers read zero.
  always_comb begin
    bus.rdata = 32'd0;
    case (bus.c0_raddr)
      REG_BADVADDR: bus.rdata = badvaddr;
      REG_COUNT:    bus.rdata = count;
      REG_COMPARE:  bus.rdata = compare;
      REG_STATUS:   bus.rdata = {9'b0, RESET_BEV, 6'b0, im, 6'b0, exl, ie};
      REG_CAUSE:    bus.rdata = {bd, ti, 14'b0, ip, 1'b0, excode, 2'b0};
      REG_EPC:      bus.rdata = epc_q;
      default:      bus.rdata = 32'd0;
    endcase
  end

  assign bus.epc     = epc_q;
  assign bus.has_int = (|(ip & im)) & ie & ~exl;

endmodule

// File: tb/tb_cp0_regfile_p.sv
// Directed stimulus for cp0_regfile_p with a scoreboard queue and a separate monitor.
// Stimulus pushes the expected value and fires a sample event; the monitor pops and compares.
// Default parameters: EXT_INT_W=6, COUNT_DIV=2, RESET_BEV=1.
module tb_cp0_regfile_p;

`ifdef CP0_INT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       reset;
  logic [5:0] ext_int_in;

  cp0_regfile_p_if bus ();

  cp0_regfile_p #(.EXT_INT_W(6), .COUNT_DIV(2), .RESET_BEV(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .ext_int_in (ext_int_in),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // kind: 0 = rdata, 1 = has_int, 2 = epc
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] val;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  event  smp;
  logic  final_chk = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;

  // Monitor: pop the next expectation and compare it with what the DUT presents.
  always @(smp) begin
    exp_t        e;
    string       nm;
    logic [31:0] act;
    if (final_chk) begin
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL sb_drain: %0d left in queue, expected 0", exp_q.size());
      end
    end else if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_underflow: sample with empty scoreboard");
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      case (e.kind)
        2'd0:    act = bus.rdata;
        2'd1:    act = {31'b0, bus.has_int};
        default: act = bus.epc;
      endcase
      n_cmp++;
      if (act !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %08h expected %08h", nm, act, e.val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [1:0] kind, input logic [4:0] addr,
                     input logic [31:0] val, input string nm);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    bus.c0_raddr = addr;
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
    -> smp;
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.mtc0_we  = 1'b1;
    bus.c0_waddr = a;
    bus.c0_wdata = d;
    tick(1);
    bus.mtc0_we  = 1'b0;
  endtask

  task automatic raise_ex(input logic [4:0] code, input logic bdv,
                          input logic [31:0] pc, input logic [31:0] bva);
    bus.wb_ex       = 1'b1;
    bus.wb_excode   = code;
    bus.wb_bd       = bdv;
    bus.wb_pc       = pc;
    bus.wb_badvaddr = bva;
    tick(1);
    bus.wb_ex       = 1'b0;
  endtask

  task automatic eret();
    bus.eret_flush = 1'b1;
    tick(1);
    bus.eret_flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    ext_int_in      = '0;
    bus.wb_ex       = 1'b0;
    bus.wb_excode   = '0;
    bus.wb_badvaddr = '0;
    bus.wb_bd       = 1'b0;
    bus.wb_pc       = '0;
    bus.eret_flush  = 1'b0;
    bus.mtc0_we     = 1'b0;
    bus.c0_waddr    = '0;
    bus.c0_wdata    = '0;
    bus.c0_raddr    = '0;
    tick(2);
    reset = 1'b0;

    // Reset state
    chk(0, 5'd12, 32'h0040_0000, "rst_status");
    chk(0, 5'd13, 32'h0000_0000, "rst_cause");
    chk(1, 5'd0,  32'd0,         "rst_has_int");
    chk(0, 5'd9,  32'h0000_0000, "rst_count");
    chk(2, 5'd0,  32'h0000_0000, "rst_epc");
    tick(1);
    chk(0, 5'd13, 32'h4000_0000, "ti_after_rst");
    chk(0, 5'd9,  32'h0000_0000, "count_presc_hold");
    tick(1);
    chk(0, 5'd13, 32'h4000_8000, "ip7_from_ti");
    chk(0, 5'd9,  32'h0000_0001, "count_first_inc");

    // Count wrap with prescaler 2
    mtc0(5'd9, 32'hFFFF_FFFE);
    chk(0, 5'd9, 32'hFFFF_FFFE, "count_load");
    tick(2);
    chk(0, 5'd9, 32'hFFFF_FFFF, "count_plus1");
    tick(2);
    chk(0, 5'd9, 32'h0000_0000, "count_wrap");

    // Timer interrupt
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd5);
    chk(0, 5'd13, 32'h0000_0000, "ti_cleared_by_compare");
    chk(0, 5'd9,  32'd5,         "count_5");
    tick(10);
    chk(0, 5'd9,  32'd10,        "count_10");
    chk(0, 5'd13, 32'h0000_0000, "ti_not_yet");
    tick(1);
    chk(0, 5'd13, 32'h4000_0000, "ti_set");
    mtc0(5'd11, 32'd20);
    chk(0, 5'd13, 32'h0000_8000, "compare_wr_beats_set");
    chk(0, 5'd11, 32'd20,        "compare_rd");
    mtc0(5'd11, 32'h8000_0000);
    chk(0, 5'd13, 32'h0000_0000, "ip7_drops");

    // External interrupt, EXL masking, ERET
    mtc0(5'd12, 32'h0000_0401);
    chk(0, 5'd12, 32'h0040_0401, "status_wr");
    chk(1, 5'd0,  32'd0,         "no_int_yet");
    ext_int_in = 6'b000001;
    chk(1, 5'd0,  32'd0,         "int_same_cycle");
    tick(LAT - 1);
    chk(1, 5'd0,  32'd0,         "int_before_lat");
    tick(1);
    chk(1, 5'd0,  32'd1,         "int_after_lat");
    raise_ex(5'd0, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF);
    chk(1, 5'd0,  32'd0,         "exl_masks_int");
    chk(0, 5'd12, 32'h0040_0403, "status_exl");
    chk(2, 5'd0,  32'h8000_0010, "epc_no_bd");
    chk(0, 5'd8,  32'h0000_0000, "bva_not_adel");
    eret();
    chk(1, 5'd0,  32'd1,         "eret_has_int");
    chk(0, 5'd12, 32'h0040_0401, "eret_status");

    // Delay-slot AdEL, then nested exception
    raise_ex(5'd4, 1'b1, 32'hBFC0_0104, 32'h1234_5671);
    chk(2, 5'd0,  32'hBFC0_0100, "epc_bd");
    chk(0, 5'd14, 32'hBFC0_0100, "epc_rd");
    chk(0, 5'd8,  32'h1234_5671, "bva_adel");
    chk(0, 5'd13, 32'h8000_0410, "cause_adel_bd");
    raise_ex(5'd12, 1'b0, 32'h1111_1110, 32'hAAAA_AAAA);
    chk(2, 5'd0,  32'hBFC0_0100, "nested_epc_kept");
    chk(0, 5'd13, 32'h8000_0430, "nested_cause");
    chk(0, 5'd8,  32'h1234_5671, "nested_bva_kept");
    eret();
    chk(0, 5'd12, 32'h0040_0401, "eret2_status");

    // Same-cycle priority: wb_ex beats eret and MTC0
    bus.wb_ex       = 1'b1;
    bus.wb_excode   = 5'd0;
    bus.wb_bd       = 1'b0;
    bus.wb_pc       = 32'h2000_0000;
    bus.wb_badvaddr = 32'h0;
    bus.eret_flush  = 1'b1;
    bus.mtc0_we     = 1'b1;
    bus.c0_waddr    = 5'd12;
    bus.c0_wdata    = 32'h0;
    tick(1);
    bus.wb_ex = 1'b0; bus.eret_flush = 1'b0; bus.mtc0_we = 1'b0;
    chk(0, 5'd12, 32'h0040_0403, "prio_status");
    chk(1, 5'd0,  32'd0,         "prio_has_int");
    chk(2, 5'd0,  32'h2000_0000, "prio_epc");
    chk(0, 5'd13, 32'h0000_0400, "prio_cause");

    // ERET beats MTC0 to EPC
    bus.eret_flush = 1'b1;
    bus.mtc0_we    = 1'b1;
    bus.c0_waddr   = 5'd14;
    bus.c0_wdata   = 32'h5555_0000;
    tick(1);
    bus.eret_flush = 1'b0; bus.mtc0_we = 1'b0;
    chk(2, 5'd0,  32'h2000_0000, "eret_drops_mtc0");
    chk(0, 5'd12, 32'h0040_0401, "eret_prio_status");

    // Plain MTC0 fields and read-only registers
    mtc0(5'd14, 32'hCAFE_0000);
    chk(2, 5'd0,  32'hCAFE_0000, "mtc0_epc");
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk(0, 5'd13, 32'h0000_0700, "mtc0_cause_ip_sw");
    mtc0(5'd8, 32'hFFFF_FFFF);
    chk(0, 5'd8,  32'h1234_5671, "bva_read_only");
    chk(0, 5'd15, 32'h0000_0000, "unmapped_reg");
    mtc0(5'd12, 32'hFFFF_FFFF);
    chk(0, 5'd12, 32'h0040_FF03, "status_ro_bits");
    chk(1, 5'd0,  32'd0,         "status_exl_masks");

    // Reset during an exception
    reset           = 1'b1;
    bus.wb_ex       = 1'b1;
    bus.wb_excode   = 5'd4;
    bus.wb_pc       = 32'h3000_0000;
    bus.wb_badvaddr = 32'h7777_7777;
    tick(1);
    reset = 1'b0; bus.wb_ex = 1'b0;
    chk(0, 5'd12, 32'h0040_0000, "rst_mid_status");
    chk(2, 5'd0,  32'h0000_0000, "rst_mid_epc");
    chk(0, 5'd13, 32'h0000_0000, "rst_mid_cause");
    chk(0, 5'd8,  32'h0000_0000, "rst_mid_bva");

    final_chk = 1'b1;
    #1;
    -> smp;
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
